// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Result and carry-out are registered on the completion edge and flagged by a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             load_c;
    logic             last_c;
    logic             bit_s_c;
    logic             bit_co_c;
    logic [WIDTH-1:0] s_next_c;

    // Full-adder cell on the current LSBs.
    always_comb begin
        bit_s_c  = a_sh[0] ^ b_sh[0] ^ carry;
        bit_co_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        s_next_c = {bit_s_c, s_sh[WIDTH-1:1]};
        last_c   = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are accepted whenever the adder is not running (IDLE or DONE).
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (load_c) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                s_sh  <= s_next_c;
                carry <= bit_co_c;
                cnt   <= cnt + CNT_W'(1);
                // Publish the result only on the final bit.
                if (last_c) begin
                    sum  <= s_next_c;
                    cout <= bit_co_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, random operands and a 4-bit exhaustive sweep
// compared against plain integer addition.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         rst4;
    logic         start4;
    logic [3:0]   a4;
    logic [3:0]   b4;
    logic         cin4;
    logic         busy4;
    logic         done4;
    logic [3:0]   sum4;
    logic         cout4;

    int errors = 0;
    int checks = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction on the 8-bit unit; optionally pulses a stray start at RUN cycle inj_k.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input int inj_k, input string tag);
        logic [W:0]   exp;
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        int           done_k;
        int           pulses;
        int           busy_n;
        bit           held;
        bit           both;
        exp       = (W+1)'(ta) + (W+1)'(tb_v) + (W+1)'(tc);
        prev_sum  = sum;
        prev_cout = cout;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; cin = tc;
        @(posedge clk);
        done_k = -1; pulses = 0; busy_n = 0; held = 1'b1; both = 1'b0;
        for (int k = 0; k <= int'(W) + 3; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulses++;
                if (done_k < 0) begin
                    done_k = k;
                    check({tag, ".sum"}, 32'(sum), 32'(exp[W-1:0]));
                    check({tag, ".cout"}, 32'(cout), 32'(exp[W]));
                end
            end
            if (busy) busy_n++;
            if (busy && done) both = 1'b1;
            if (done_k < 0 && (sum !== prev_sum || cout !== prev_cout)) held = 1'b0;
            if (k == 0) begin
                start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            if (k == inj_k) begin
                start = 1'b1; a = '1; b = '1;
            end
            if (k == inj_k + 1) start = 1'b0;
        end
        check({tag, ".lat"}, 32'(done_k), 32'(W));
        check({tag, ".pulses"}, 32'(pulses), 32'd1);
        check({tag, ".busy_n"}, 32'(busy_n), 32'(W));
        check({tag, ".held"}, 32'(held), 32'd1);
        check({tag, ".overlap"}, 32'(both), 32'd0);
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
        logic [4:0] exp;
        bit         seen;
        exp  = 5'(ta) + 5'(tb_v) + 5'(tc);
        seen = 1'b0;
        @(negedge clk);
        start4 = 1'b1; a4 = ta; b4 = tb_v; cin4 = tc;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (done4) seen = 1'b1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (seen) check($sformatf("sweep %0h+%0h+%0h", ta, tb_v, tc), 32'({cout4, sum4}), 32'(exp));
        else check("sweep.timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int pulses;
        int d1;
        int d2;
        logic [W-1:0] mid_sum;
        bit held;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.sum", 32'(sum), 32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        rst = 1'b0; rst4 = 1'b0;

        op(8'h5A, 8'h33, 1'b0, -1, "basic");
        check("basic.const", 32'({cout, sum}), 32'h08D);
        op(8'hFF, 8'h01, 1'b0, -1, "ovf1");
        check("ovf1.const", 32'({cout, sum}), 32'h100);
        op(8'hFF, 8'hFF, 1'b1, -1, "ovf2");
        check("ovf2.const", 32'({cout, sum}), 32'h1FF);
        op(8'h10, 8'h20, 1'b0, 2, "ignore");
        check("ignore.const", 32'({cout, sum}), 32'h030);

        // Reset in the 4th RUN cycle aborts the add.
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.sum", 32'(sum), 32'd0);
        check("abort.cout", 32'(cout), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort.nodone", 32'(pulses), 32'd0);
        op(8'h01, 8'h01, 1'b0, -1, "post_rst");
        check("post_rst.const", 32'(sum), 32'h02);

        // Back-to-back: start held, new operands presented in the DONE cycle.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        @(posedge clk);
        d1 = -1; d2 = -1; mid_sum = '0; held = 1'b1;
        for (int k = 0; k <= 2 * int'(W) + 4; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (done && d1 < 0) begin
                d1 = k;
                check("b2b.r1", 32'({cout, sum}), 32'h003);
                mid_sum = sum;
                a = 8'h80; b = 8'h80;
            end else if (done && d2 < 0) begin
                d2 = k;
                check("b2b.r2", 32'({cout, sum}), 32'h100);
            end else if (d1 >= 0 && d2 < 0 && sum !== mid_sum) begin
                held = 1'b0;
            end
            if (d1 >= 0 && k == d1 + 1) start = 1'b0;
        end
        check("b2b.first", 32'(d1), 32'(W));
        check("b2b.spacing", 32'(d2 - d1), 32'(W + 1));
        check("b2b.held", 32'(held), 32'd1);

        for (int i = 0; i < 25; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom), -1, $sformatf("rand%0d", i));
        end

        for (int i = 0; i < 512; i++) begin
            op4(4'(i), 4'(i >> 4), 1'(i >> 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
